spi_reg_bridge: RTL
===================

Name: spi_reg_bridge

Overview:
- Command decoder directly downstream of the SPI slave, in the i_Clk domain.
- Consumes received bytes (RX_DV/RX_Byte) and drives the slave's TX_DV/TX_Byte inputs.
- Turns each CS-framed SPI transaction into register-bank reads/writes with address auto-increment.
- Sits between the SPI slave and the team's register bank.

Parameters:
NUM_REGS, 128, number of implemented registers (1..128); addresses >= NUM_REGS are out of range.
STATUS_BYTE, 8'hA5, byte shifted out on MISO during the command byte of every transaction.

Ports:
i_Clk  input  1  FPGA clock; all logic on rising edge.
i_Rst_L  input  1  asynchronous active-low reset.
i_SPI_CS_n  input  1  raw SPI chip select (async); synchronized internally.
i_RX_DV  input  1  one-cycle pulse from SPI slave; i_RX_Byte valid.
i_RX_Byte  input  8  received byte.
o_TX_DV  output  1  one-cycle pulse; SPI slave registers o_TX_Byte.
o_TX_Byte  output  8  next byte to shift out on MISO.
o_Reg_Addr  output  7  register address.
o_Reg_Wr_En  output  1  one-cycle write strobe.
o_Reg_Wr_Data  output  8  write data, valid with o_Reg_Wr_En.
o_Reg_Rd_En  output  1  one-cycle read strobe.
i_Reg_Rd_Data  input  8  read data, valid exactly 1 cycle after o_Reg_Rd_En.
o_Busy  output  1  high while a transaction is open (synchronized CS low).
o_Err  output  1  one-cycle pulse on protocol or range error.

Behaviour:
- Reset (async, i_Rst_L low): every output 0; o_Reg_Addr 0; o_TX_Byte 8'h00; state IDLE; CS synchronizer flops preset to 1.
- CS sync: 2-flop synchronizer plus a third edge-detect flop.
  - Falling edge = start; rising edge = end.
- States:
  - IDLE: on start -> CMD; same cycle pulse o_TX_DV with o_TX_Byte=STATUS_BYTE; o_Busy=1.
  - CMD: on i_RX_DV, latch cmd = i_RX_Byte.
    - Address = cmd[6:0].
    - cmd[7]=1 -> WR; cmd[7]=0 -> RD_FETCH.
    - RD_FETCH is entered with o_Reg_Rd_En pulsed in the same cycle the command is latched, for an in-range address.
  - WR: each i_RX_DV -> o_Reg_Wr_En=1, o_Reg_Wr_Data=i_RX_Byte, o_Reg_Addr=current address (registered, appears next cycle); then address+1.
  - RD_FETCH: 1-cycle wait state. Next cycle: o_TX_DV=1, o_TX_Byte=i_Reg_Rd_Data (8'h00 if out of range); -> RD.
    - Latency i_RX_DV -> o_TX_DV = 2 cycles.
  - RD: each i_RX_DV (dummy byte, value ignored) -> address+1, o_Reg_Rd_En for the new address, -> RD_FETCH.
- Address arithmetic: 7-bit, wraps 127->0. Out-of-range check is addr >= NUM_REGS, evaluated per access.
  - Out-of-range write: o_Reg_Wr_En suppressed, o_Err pulse.
  - Out-of-range read: o_Reg_Rd_En suppressed, TX byte 8'h00, o_Err pulse.
- End of transaction: an end detect in any state -> IDLE next cycle, o_Busy=0.
  - An i_RX_DV in the same cycle as end detect is processed first: a final write still occurs; a read prefetch is dropped.
- i_RX_DV in IDLE: ignored, o_Err pulse.
- Start and end in consecutive cycles: start handled, then end; no register access.
- Strobes o_Reg_Wr_En, o_Reg_Rd_En and o_TX_DV are never high for more than 1 cycle and never coincide with each other.
- Mid-operation reset: immediate return to reset values; no strobe is emitted until after a fresh start.

Test Plan:
- Reset with CS high -> all outputs 0; after CS falls, o_TX_DV pulses once within 4 cycles with o_TX_Byte=8'hA5; o_Busy=1.
- Write burst: bytes 8'h85, 8'h11, 8'h22, 8'h33 -> writes (addr 5, 8'h11), (6, 8'h22), (7, 8'h33); no o_Err.
- Read burst: bank reg 10=8'h5A, reg 11=8'hC3; bytes 8'h0A, dummy, dummy -> o_TX_Byte 8'h5A 2 cycles after first RX_DV, then 8'hC3.
- NUM_REGS=16, cmd 8'h8F then 2 data bytes -> write to addr 15, then suppressed write at addr 16 with one o_Err pulse; read cmd 8'h20 -> TX 8'h00, o_Err.
- Wrap: NUM_REGS=128, write cmd 8'hFF with 2 data bytes -> writes to addr 127 then addr 0.
- Protocol edges: i_RX_DV with CS high -> o_Err, no strobes; CS rise coincident with last write RX_DV -> write occurs, then IDLE; reset asserted mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/spi_reg_bridge_if.sv
// Signal bundle joining the SPI slave byte interface, the register bank and
// the status outputs of spi_reg_bridge.
interface spi_reg_bridge_if;
   logic       spi_cs_n;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic       tx_dv;
   logic [7:0] tx_byte;
   logic [6:0] reg_addr;
   logic       reg_wr_en;
   logic [7:0] reg_wr_data;
   logic       reg_rd_en;
   logic [7:0] reg_rd_data;
   logic       busy;
   logic       err;

   modport slave (
      input  spi_cs_n, rx_dv, rx_byte, reg_rd_data,
      output tx_dv, tx_byte, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy, err
   );

   modport master (
      output spi_cs_n, rx_dv, rx_byte, reg_rd_data,
      input  tx_dv, tx_byte, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy, err
   );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI command decoder: turns CS-framed byte streams from the SPI slave into
// auto-incrementing register-bank reads and writes.
module spi_reg_bridge #(
   parameter int         NUM_REGS    = 128,
   parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
   input logic             i_Clk,
   input logic             i_Rst_L,
   spi_reg_bridge_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CMD, WR, RD_FETCH, RD} state_t;

   // One bit per address: set where a register is implemented.
   localparam logic [127:0] REG_MASK = (NUM_REGS >= 128) ? {128{1'b1}}
                                     : ((128'd1 << NUM_REGS) - 128'd1);

   function automatic logic in_range(input logic [6:0] a);
      return REG_MASK[a];
   endfunction

   state_t     state, state_n;
   logic       cs_s0, cs_s1, cs_s2;
   logic       start_det, end_det;
   logic [6:0] ptr, ptr_n, ptr_inc;
   logic [6:0] addr, addr_n;
   logic       wr_en, wr_en_n;
   logic [7:0] wr_data, wr_data_n;
   logic       rd_en, rd_en_n;
   logic       tx_dv, tx_dv_n;
   logic       rd_tx, rd_tx_n;
   logic       rd_oor, rd_oor_n;
   logic [7:0] tx_hold, tx_hold_n;
   logic [7:0] rd_byte;
   logic       busy, busy_n;
   logic       err, err_n;

   assign start_det = cs_s2 & ~cs_s1;
   assign end_det   = ~cs_s2 & cs_s1;
   assign ptr_inc   = ptr + 7'd1;
   // Read data arrives one cycle after the strobe, so it is passed straight
   // through during the TX pulse and held afterwards.
   assign rd_byte   = rd_oor ? 8'h00 : bus.reg_rd_data;

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      addr_n    = addr;
      wr_en_n   = 1'b0;
      wr_data_n = wr_data;
      rd_en_n   = 1'b0;
      tx_dv_n   = 1'b0;
      rd_tx_n   = 1'b0;
      rd_oor_n  = rd_oor;
      tx_hold_n = rd_tx ? rd_byte : tx_hold;
      busy_n    = busy;
      err_n     = 1'b0;
      case (state)
         IDLE: begin
            err_n = bus.rx_dv;
            if (start_det) begin
               state_n   = CMD;
               tx_dv_n   = 1'b1;
               tx_hold_n = STATUS_BYTE;
               busy_n    = 1'b1;
            end
         end
         CMD: begin
            if (bus.rx_dv) begin
               ptr_n  = bus.rx_byte[6:0];
               addr_n = bus.rx_byte[6:0];
               if (bus.rx_byte[7]) begin
                  state_n = WR;
               end else begin
                  state_n = RD_FETCH;
                  rd_en_n = in_range(bus.rx_byte[6:0]);
                  err_n   = ~in_range(bus.rx_byte[6:0]);
               end
            end
         end
         WR: begin
            if (bus.rx_dv) begin
               addr_n    = ptr;
               wr_data_n = bus.rx_byte;
               wr_en_n   = in_range(ptr);
               err_n     = ~in_range(ptr);
               ptr_n     = ptr_inc;
            end
         end
         RD_FETCH: begin
            state_n  = RD;
            tx_dv_n  = 1'b1;
            rd_tx_n  = 1'b1;
            rd_oor_n = ~in_range(ptr);
         end
         RD: begin
            if (bus.rx_dv) begin
               ptr_n   = ptr_inc;
               addr_n  = ptr_inc;
               rd_en_n = in_range(ptr_inc);
               err_n   = ~in_range(ptr_inc);
               state_n = RD_FETCH;
            end
         end
         default: state_n = IDLE;
      endcase
      // A closing CS keeps a coincident final write but drops any read work.
      if (end_det) begin
         state_n = IDLE;
         busy_n  = 1'b0;
         rd_en_n = 1'b0;
         tx_dv_n = 1'b0;
         rd_tx_n = 1'b0;
         if (state == CMD || state == RD) err_n = 1'b0;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         cs_s0   <= 1'b1;
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         state   <= IDLE;
         ptr     <= 7'd0;
         addr    <= 7'd0;
         wr_en   <= 1'b0;
         wr_data <= 8'h00;
         rd_en   <= 1'b0;
         tx_dv   <= 1'b0;
         rd_tx   <= 1'b0;
         rd_oor  <= 1'b0;
         tx_hold <= 8'h00;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         cs_s0   <= bus.spi_cs_n;
         cs_s1   <= cs_s0;
         cs_s2   <= cs_s1;
         state   <= state_n;
         ptr     <= ptr_n;
         addr    <= addr_n;
         wr_en   <= wr_en_n;
         wr_data <= wr_data_n;
         rd_en   <= rd_en_n;
         tx_dv   <= tx_dv_n;
         rd_tx   <= rd_tx_n;
         rd_oor  <= rd_oor_n;
         tx_hold <= tx_hold_n;
         busy    <= busy_n;
         err     <= err_n;
      end
   end

   assign bus.tx_dv       = tx_dv;
   assign bus.tx_byte     = rd_tx ? rd_byte : tx_hold;
   assign bus.reg_addr    = addr;
   assign bus.reg_wr_en   = wr_en;
   assign bus.reg_wr_data = wr_data;
   assign bus.reg_rd_en   = rd_en;
   assign bus.busy        = busy;
   assign bus.err         = err;
endmodule
